mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one off-chip memory port between the two channels of an HLS accelerator's master interface (Mout_oe_ram/Mout_we_ram/Mout_addr_ram, per-channel DataRdy).
- Sits between the accelerator's 2-channel master bus and a single-ported external memory model/controller.
- Grants one channel at a time, round-robin.
- Holds the grant until the memory acknowledges, with a timeout watchdog.

Parameters:
- ADDR_W, 7, address width per channel.
- DATA_W, 8, data width per channel.
- SIZE_W, 4, access-size field width per channel.
- TIMEOUT, 255, maximum cycles a grant waits for mem_rdy before forced completion; must be >=2.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_oe  in  2  per-channel read request; bit i = channel i.
- req_we  in  2  per-channel write request.
- req_addr  in  2*ADDR_W  channel i address in bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  2*DATA_W  per-channel write data.
- req_size  in  2*SIZE_W  per-channel access size.
- req_rdata  out  2*DATA_W  per-channel read data.
- req_rdy  out  2  per-channel completion pulse.
- mem_oe  out  1  memory read enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_size  out  SIZE_W  memory access size.
- mem_rdata  in  DATA_W  memory read data, valid with mem_rdy.
- mem_rdy  in  1  memory completion, one-cycle pulse.
- busy  out  1  high while a grant is active.
- err_both  out  1  sticky: some channel asserted oe and we together.
- err_timeout  out  1  sticky: a grant hit TIMEOUT.

Behaviour:
- Reset (reset=0, async): state=IDLE, grant=0, last=1 (so channel 0 wins first), cnt=0, all outputs 0.
- Requester contract: oe/we, addr, wdata and size stay stable from assertion until the cycle req_rdy[i]=1. The requester drops or changes the request in the following cycle.
- States:
  - IDLE: if any req_oe|req_we bit is set, go to BUSY.
    - grant <= the requesting channel; if both request, the channel != last.
    - cnt <= 0.
  - BUSY: mem_oe/mem_we/mem_addr/mem_wdata/mem_size are combinationally the granted channel's signals. busy=1.
    - On mem_rdy=1: req_rdy[grant]=1 that same cycle; req_rdata[grant]=mem_rdata (combinational, that cycle only, else 0); last <= grant; go to IDLE.
    - Else, if cnt==TIMEOUT-1: req_rdy[grant]=1 with rdata 0; err_timeout <= 1; last <= grant; go to IDLE.
    - Else cnt <= cnt+1.
- In IDLE all mem_* outputs are 0. The minimum per-access cost is therefore 1 IDLE cycle plus the memory latency.
- The ungranted channel's req_rdy is always 0. mem_rdy arriving in IDLE is ignored.
- If the granted channel drops its request in BUSY (contract violation): mem_oe/mem_we fall to 0, but the grant is held until mem_rdy or timeout.
- err_both: set on any cycle where req_oe[i]&req_we[i] for either i. Cleared only by reset. When both are set on the granted channel, mem_we is suppressed (read takes precedence).
- cnt width: clog2(TIMEOUT+1).
- Reset mid-BUSY aborts the access immediately. No req_rdy is issued.

Test Plan:
- Single read: ch0 read addr 0x05; memory returns 0xA5 with mem_rdy two cycles after mem_oe -> mem_addr=0x05 during BUSY, req_rdy=2'b01 for one cycle with req_rdata[7:0]=0xA5, busy falls next cycle.
- Simultaneous: both channels write from reset (ch0 0x11 @0x01, ch1 0x22 @0x02), memory acks after 1 cycle -> ch0 served first, then ch1. Repeated simultaneous traffic alternates 0,1,0,1.
- Back-to-back one channel: ch1 issues 4 reads, ch0 idle -> ch1 granted each time; no grant to ch0; 4 req_rdy[1] pulses.
- Timeout: TIMEOUT=8, ch0 read, mem_rdy never asserted -> req_rdy[0] pulses exactly 8 cycles into BUSY, rdata 0, err_timeout=1 and stays 1.
- err_both: ch1 asserts oe and we at addr 0x10 -> err_both=1 next edge, mem_we=0, mem_oe=1, transaction completes as a read.
- Async reset mid-BUSY: drop reset while ch0 is waiting -> all outputs 0 immediately with no clock edge; after release, first simultaneous request grants ch0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundles the two-channel requester bus, the shared memory port and status flags.
// slave = arbiter view, master = requester/memory-side view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int SIZE_W = 4
);
  logic [1:0]          req_oe;
  logic [1:0]          req_we;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [2*SIZE_W-1:0] req_size;
  logic [2*DATA_W-1:0] req_rdata;
  logic [1:0]          req_rdy;
  logic                mem_oe;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [SIZE_W-1:0]   mem_size;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_rdy;
  logic                busy;
  logic                err_both;
  logic                err_timeout;

  modport slave (
    input  req_oe, req_we, req_addr, req_wdata, req_size, mem_rdata, mem_rdy,
    output req_rdata, req_rdy, mem_oe, mem_we, mem_addr, mem_wdata, mem_size,
           busy, err_both, err_timeout
  );

  modport master (
    output req_oe, req_we, req_addr, req_wdata, req_size, mem_rdata, mem_rdy,
    input  req_rdata, req_rdy, mem_oe, mem_we, mem_addr, mem_wdata, mem_size,
           busy, err_both, err_timeout
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between two requester channels,
// holding each grant until mem_rdy or a watchdog timeout.
//
// state | meaning
// IDLE  | no grant; mem_* outputs forced to 0, picks next channel
// BUSY  | grant_q owns the memory port until mem_rdy or timeout
module mem_port_arbiter #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8,
  parameter int SIZE_W  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                clock,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_both_q, err_both_d;
  logic              err_timeout_q, err_timeout_d;

  logic [1:0]          any_req;
  logic [2*DATA_W-1:0] req_rdata;
  logic [1:0]          req_rdy;
  logic                mem_oe;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [SIZE_W-1:0]   mem_size;
  logic                busy;

  assign any_req = bus.req_oe | bus.req_we;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      grant_q       <= 1'b0;
      last_q        <= 1'b1;
      cnt_q         <= '0;
      err_both_q    <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      err_both_q    <= err_both_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    err_timeout_d = err_timeout_q;
    err_both_d    = err_both_q | (|(bus.req_oe & bus.req_we));
    req_rdata     = '0;
    req_rdy       = '0;
    mem_oe        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_size      = '0;
    busy          = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|any_req) begin
          state_d = BUSY;
          cnt_d   = '0;
          // with both requesting, the channel not served last wins
          grant_d = (&any_req) ? ~last_q : any_req[1];
        end
      end
      BUSY: begin
        busy      = 1'b1;
        mem_oe    = bus.req_oe[grant_q];
        mem_we    = bus.req_we[grant_q] & ~bus.req_oe[grant_q];
        mem_addr  = bus.req_addr[int'(grant_q)*ADDR_W +: ADDR_W];
        mem_wdata = bus.req_wdata[int'(grant_q)*DATA_W +: DATA_W];
        mem_size  = bus.req_size[int'(grant_q)*SIZE_W +: SIZE_W];
        if (bus.mem_rdy) begin
          req_rdy[grant_q]                          = 1'b1;
          req_rdata[int'(grant_q)*DATA_W +: DATA_W] = bus.mem_rdata;
          last_d                                    = grant_q;
          state_d                                   = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          req_rdy[grant_q] = 1'b1;
          err_timeout_d    = 1'b1;
          last_d           = grant_q;
          state_d          = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_rdata   = req_rdata;
  assign bus.req_rdy     = req_rdy;
  assign bus.mem_oe      = mem_oe;
  assign bus.mem_we      = mem_we;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wdata   = mem_wdata;
  assign bus.mem_size    = mem_size;
  assign bus.busy        = busy;
  assign bus.err_both    = err_both_q;
  assign bus.err_timeout = err_timeout_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a latency-programmable memory model,
// a batch requester driver and a completion monitor popping expected results.
module tb_mem_port_arbiter;
  localparam int TIMEOUT = 8;

  typedef struct {
    logic       ch;
    logic       oe;
    logic       we;
    logic [6:0] addr;
    logic [3:0] size;
    logic [7:0] rdata;
    int         cyc;
  } sb_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_W(7), .DATA_W(8), .SIZE_W(4)) bus ();

  mem_port_arbiter #(.ADDR_W(7), .DATA_W(8), .SIZE_W(4), .TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  sb_t        sb[$];
  logic [7:0] tb_mem [128];
  logic [7:0] exp_mem[128];
  logic       mem_en = 1'b1;
  int         mem_lat = 0;
  int         wcnt = 0;
  int         busy_cyc = 0;
  logic       model_last = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // memory model: acks mem_lat cycles after the grant starts
  initial forever begin
    @(posedge clock);
    #2;
    bus.mem_rdy   = 1'b0;
    bus.mem_rdata = '0;
    if (bus.busy && mem_en) begin
      if (wcnt == mem_lat) begin
        bus.mem_rdy = 1'b1;
        if (bus.mem_oe) bus.mem_rdata = tb_mem[bus.mem_addr];
        else if (bus.mem_we) tb_mem[bus.mem_addr] = bus.mem_wdata;
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  initial forever begin
    sb_t e;
    @(negedge clock);
    if (bus.busy) busy_cyc++;
    else busy_cyc = 0;
    if (bus.req_rdy != 2'b00) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_rdy", 32'(bus.req_rdy), 32'd0);
      end else begin
        e = sb.pop_front();
        check("rdy_chan", 32'(bus.req_rdy), 32'(2'b01 << e.ch));
        check("rdata", 32'(bus.req_rdata[int'(e.ch)*8 +: 8]), 32'(e.rdata));
        check("rdata_other", 32'(bus.req_rdata[int'(~e.ch)*8 +: 8]), 32'd0);
        check("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
        check("mem_oe", 32'(bus.mem_oe), 32'(e.oe));
        check("mem_we", 32'(bus.mem_we), 32'(e.we));
        check("mem_size", 32'(bus.mem_size), 32'(e.size));
        check("busy_cycles", 32'(busy_cyc), 32'(e.cyc));
      end
    end
  end

  function automatic void push_entry(input logic c, input logic oe, input logic we,
                                     input logic [6:0] a, input logic [7:0] wd,
                                     input logic [3:0] sz);
    sb_t e;
    e.ch    = c;
    e.oe    = oe;
    e.we    = we & ~oe;
    e.addr  = a;
    e.size  = sz;
    e.rdata = '0;
    if (mem_en) begin
      e.cyc = mem_lat + 1;
      if (oe) e.rdata = exp_mem[a];
      else if (we) exp_mem[a] = wd;
    end else begin
      e.cyc = TIMEOUT;
    end
    sb.push_back(e);
  endfunction

  task automatic run_batch(input logic [1:0] mask, input logic [1:0] oe, input logic [1:0] we,
                           input logic [6:0] a0, input logic [6:0] a1,
                           input logic [7:0] w0, input logic [7:0] w1,
                           input logic [3:0] s0, input logic [3:0] s1);
    logic [1:0] pending;
    logic [1:0] seen;
    logic       first;
    @(posedge clock);
    #1;
    bus.req_oe    = oe & mask;
    bus.req_we    = we & mask;
    bus.req_addr  = {a1, a0};
    bus.req_wdata = {w1, w0};
    bus.req_size  = {s1, s0};
    if (mask == 2'b11) begin
      first = ~model_last;
      if (first) begin
        push_entry(1'b1, oe[1], we[1], a1, w1, s1);
        push_entry(1'b0, oe[0], we[0], a0, w0, s0);
      end else begin
        push_entry(1'b0, oe[0], we[0], a0, w0, s0);
        push_entry(1'b1, oe[1], we[1], a1, w1, s1);
      end
      model_last = ~first;
    end else begin
      if (mask[1]) push_entry(1'b1, oe[1], we[1], a1, w1, s1);
      else         push_entry(1'b0, oe[0], we[0], a0, w0, s0);
      model_last = mask[1];
    end
    pending = mask;
    for (int i = 0; i < 200 && pending != 2'b00; i++) begin
      @(negedge clock);
      seen = bus.req_rdy & pending;
      @(posedge clock);
      #1;
      bus.req_oe = bus.req_oe & ~seen;
      bus.req_we = bus.req_we & ~seen;
      pending    = pending & ~seen;
    end
    if (pending != 2'b00) begin
      check("batch_done", 32'(pending), 32'd0);
      bus.req_oe = '0;
      bus.req_we = '0;
    end
  endtask

  initial begin
    bus.req_oe    = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_size  = '0;
    bus.mem_rdy   = 1'b0;
    bus.mem_rdata = '0;
    for (int i = 0; i < 128; i++) begin
      tb_mem[i]  = 8'(i) ^ 8'h5A;
      exp_mem[i] = 8'(i) ^ 8'h5A;
    end
    tb_mem[5]  = 8'hA5;
    exp_mem[5] = 8'hA5;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_mem_oe", 32'(bus.mem_oe), 32'd0);
    check("rst_req_rdy", 32'(bus.req_rdy), 32'd0);
    check("rst_err_both", 32'(bus.err_both), 32'd0);
    check("rst_err_timeout", 32'(bus.err_timeout), 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;

    // simultaneous writes from reset: ch0 first, then ch1
    mem_lat = 1;
    run_batch(2'b11, 2'b00, 2'b11, 7'h01, 7'h02, 8'h11, 8'h22, 4'h1, 4'h2);
    // repeated simultaneous reads keep alternating and read back the writes
    mem_lat = 0;
    run_batch(2'b11, 2'b11, 2'b00, 7'h01, 7'h02, 8'h00, 8'h00, 4'h3, 4'h4);
    mem_lat = 3;
    run_batch(2'b11, 2'b11, 2'b00, 7'h02, 7'h01, 8'h00, 8'h00, 4'h5, 4'h6);

    // single read on ch0
    mem_lat = 2;
    run_batch(2'b01, 2'b01, 2'b00, 7'h05, 7'h00, 8'h00, 8'h00, 4'h7, 4'h0);
    check("busy_after_read", 32'(bus.busy), 32'd0);

    // back-to-back reads on ch1 only
    mem_lat = 1;
    for (int k = 0; k < 4; k++)
      run_batch(2'b10, 2'b10, 2'b00, 7'h00, 7'(8'h20 + k), 8'h00, 8'h00, 4'h0, 4'(k));
    check("err_both_clear", 32'(bus.err_both), 32'd0);

    // ch1 asserts oe and we together: completes as a read
    mem_lat = 1;
    run_batch(2'b10, 2'b10, 2'b10, 7'h00, 7'h10, 8'h00, 8'hEE, 4'h0, 4'h9);
    check("err_both_set", 32'(bus.err_both), 32'd1);
    check("err_timeout_clear", 32'(bus.err_timeout), 32'd0);

    // watchdog: memory never answers
    mem_en = 1'b0;
    run_batch(2'b01, 2'b01, 2'b00, 7'h30, 7'h00, 8'h00, 8'h00, 4'hA, 4'h0);
    check("err_timeout_set", 32'(bus.err_timeout), 32'd1);
    mem_en  = 1'b1;
    mem_lat = 0;
    run_batch(2'b01, 2'b01, 2'b00, 7'h10, 7'h00, 8'h00, 8'h00, 4'hB, 4'h0);
    check("err_timeout_sticky", 32'(bus.err_timeout), 32'd1);

    // async reset while ch0 waits on a silent memory
    mem_en = 1'b0;
    @(posedge clock);
    #1;
    bus.req_oe   = 2'b01;
    bus.req_addr = {7'h00, 7'h07};
    repeat (3) @(posedge clock);
    #3 reset = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_mem_oe", 32'(bus.mem_oe), 32'd0);
    check("arst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("arst_req_rdy", 32'(bus.req_rdy), 32'd0);
    check("arst_err_timeout", 32'(bus.err_timeout), 32'd0);
    check("arst_err_both", 32'(bus.err_both), 32'd0);
    bus.req_oe = '0;
    bus.req_we = '0;
    @(posedge clock);
    #1 reset = 1'b1;
    model_last = 1'b1;
    mem_en     = 1'b1;
    mem_lat    = 1;
    run_batch(2'b11, 2'b11, 2'b00, 7'h05, 7'h01, 8'h00, 8'h00, 4'hC, 4'hD);

    repeat (5) @(posedge clock);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
